// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: read-side consumer for the byte-wide asynchronous FIFO.
// Pulls bytes from the FIFO (1-cycle registered read data), packs them
// little-endian into WORD_BYTES-wide words and presents them on a
// valid/ready stream. A partial word is emitted on flush or idle timeout.
//
// Ports:
//   rd_clk      clock (FIFO read-side clock)
//   rst_n       asynchronous active-low reset
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO read data, valid the cycle after fifo_rd
//   fifo_rd     FIFO read strobe
//   flush       single-cycle request to emit the current partial word
//   m_data      packed word, byte0 in bits [7:0]
//   m_keep      valid-byte mask, contiguous from bit 0
//   m_valid     output word valid
//   m_ready     downstream accept
//   m_last      word produced by flush or timeout
//   busy        bytes accumulated, read in flight or word pending
module fifo_rd_packer #(
   parameter int unsigned WORD_BYTES = 4,
   parameter int unsigned TIMEOUT    = 16,
   parameter int unsigned TMR_W      = 8
) (
   input  logic                    rd_clk,
   input  logic                    rst_n,
   input  logic                    fifo_empty,
   input  logic [7:0]              fifo_data,
   output logic                    fifo_rd,
   input  logic                    flush,
   output logic [8*WORD_BYTES-1:0] m_data,
   output logic [WORD_BYTES-1:0]   m_keep,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic                    m_last,
   output logic                    busy
);

   localparam int unsigned CNT_W = $clog2(WORD_BYTES) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORD_BYTES);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   // StDrain doubles as the flush_pending flag.
   typedef enum logic [1:0] {StFill, StHold, StDrain} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        acc_cnt_q, acc_cnt_d;
   logic [8*WORD_BYTES-1:0] acc_data_q, acc_data_d;
   logic                    rd_pend_q;
   logic [TMR_W-1:0]        timer_q, timer_d;
   logic [8*WORD_BYTES-1:0] m_data_q, m_data_d;
   logic [WORD_BYTES-1:0]   m_keep_q, m_keep_d;
   logic                    m_valid_q, m_valid_d;
   logic                    m_last_q, m_last_d;

   logic                    flush_pending;
   logic [CNT_W-1:0]        fill_sum;

   // Read issue: counts the byte in flight so the accumulator never overflows.
   always_comb begin
      flush_pending = (state_q == StDrain);
      fill_sum      = acc_cnt_q + CNT_W'(rd_pend_q);
      fifo_rd       = !fifo_empty && (fill_sum < FULL_CNT) && !flush_pending;
   end

   always_comb begin
      logic [CNT_W-1:0]        cap_cnt;
      logic [8*WORD_BYTES-1:0] cap_data;
      logic                    slot_free;
      logic                    idle_qual;
      logic                    timeout_hit;
      logic                    flush_req;
      logic                    pending_d;

      // Accumulator after this edge's capture (if any).
      cap_cnt  = fill_sum;
      cap_data = acc_data_q;
      for (int unsigned l = 0; l < WORD_BYTES; l++) begin
         if (rd_pend_q && (acc_cnt_q == CNT_W'(l))) begin
            cap_data[8*l +: 8] = fifo_data;
         end
      end

      slot_free   = !m_valid_q || m_ready;
      idle_qual   = (acc_cnt_q != '0) && (acc_cnt_q < FULL_CNT) && !rd_pend_q && fifo_empty;
      timeout_hit = (TIMEOUT != 0) && idle_qual && (timer_q == TMR_LAST);
      flush_req   = flush || flush_pending || timeout_hit;
      pending_d   = flush_req;

      acc_cnt_d  = cap_cnt;
      acc_data_d = cap_data;
      timer_d    = (idle_qual && !timeout_hit) ? timer_q + TMR_W'(1) : '0;
      m_data_d   = m_data_q;
      m_keep_d   = m_keep_q;
      m_last_d   = m_last_q;
      m_valid_d  = m_valid_q && !m_ready;

      if (slot_free && (cap_cnt == FULL_CNT)) begin
         // Full word, including one completed by the capture on this edge.
         m_data_d   = cap_data;
         m_keep_d   = '1;
         m_last_d   = flush_req;
         m_valid_d  = 1'b1;
         acc_cnt_d  = '0;
         acc_data_d = '0;
         timer_d    = '0;
         pending_d  = 1'b0;
      end else if (flush_req && !rd_pend_q && !fifo_rd && slot_free) begin
         // Drain: nothing in flight, so acc_cnt_q is final. Empty accumulator
         // just retires the flush.
         if (acc_cnt_q != '0) begin
            m_data_d  = acc_data_q;
            for (int unsigned l = 0; l < WORD_BYTES; l++) begin
               m_keep_d[l] = (CNT_W'(l) < acc_cnt_q);
            end
            m_last_d  = 1'b1;
            m_valid_d = 1'b1;
         end
         acc_cnt_d  = '0;
         acc_data_d = '0;
         timer_d    = '0;
         pending_d  = 1'b0;
      end

      if (pending_d) begin
         state_d = StDrain;
      end else if (acc_cnt_d == FULL_CNT) begin
         state_d = StHold;
      end else begin
         state_d = StFill;
      end
   end

   always_ff @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StFill;
         acc_cnt_q  <= '0;
         acc_data_q <= '0;
         rd_pend_q  <= 1'b0;
         timer_q    <= '0;
         m_data_q   <= '0;
         m_keep_q   <= '0;
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_cnt_q  <= acc_cnt_d;
         acc_data_q <= acc_data_d;
         rd_pend_q  <= fifo_rd;
         timer_q    <= timer_d;
         m_data_q   <= m_data_d;
         m_keep_q   <= m_keep_d;
         m_valid_q  <= m_valid_d;
         m_last_q   <= m_last_d;
      end
   end

   assign m_data  = m_data_q;
   assign m_keep  = m_keep_q;
   assign m_valid = m_valid_q;
   assign m_last  = m_last_q;
   assign busy    = (acc_cnt_q != '0) || rd_pend_q || m_valid_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
module tb_fifo_rd_packer;

   logic        rd_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fifo_empty;
   logic [7:0]  fifo_data = 8'h00;
   logic        fifo_rd;
   logic        flush = 1'b0;
   logic [31:0] m_data;
   logic [3:0]  m_keep;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic        m_last;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   // FIFO model: registered read data, cleared by system reset.
   logic [7:0] mem [256];
   logic [7:0] wr_ptr = 8'd0;
   logic [7:0] rd_ptr = 8'd0;
   assign fifo_empty = (wr_ptr == rd_ptr);

   // Monitors.
   int          rd_cnt = 0;
   int          empty_rd_viol = 0;
   int          out_n = 0;
   logic [31:0] log_data [64];
   logic [3:0]  log_keep [64];
   logic        log_last [64];

   fifo_rd_packer #(
      .WORD_BYTES(4),
      .TIMEOUT   (16),
      .TMR_W     (8)
   ) dut (
      .rd_clk    (rd_clk),
      .rst_n     (rst_n),
      .fifo_empty(fifo_empty),
      .fifo_data (fifo_data),
      .fifo_rd   (fifo_rd),
      .flush     (flush),
      .m_data    (m_data),
      .m_keep    (m_keep),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_last    (m_last),
      .busy      (busy)
   );

   always #5 rd_clk = ~rd_clk;

   always @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= wr_ptr;
      end else if (fifo_rd) begin
         fifo_data <= mem[rd_ptr];
         rd_ptr    <= rd_ptr + 8'd1;
      end
   end

   always @(posedge rd_clk) begin
      if (fifo_rd) rd_cnt <= rd_cnt + 1;
      if (fifo_rd && fifo_empty) empty_rd_viol <= empty_rd_viol + 1;
      if (rst_n && m_valid && m_ready && out_n < 64) begin
         log_data[out_n] <= m_data;
         log_keep[out_n] <= m_keep;
         log_last[out_n] <= m_last;
         out_n           <= out_n + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge rd_clk);
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr      = wr_ptr + 8'd1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          base_rd;
      int          base_out;
      int          cyc;
      logic [31:0] w;

      // Reset values.
      step(2);
      check_eq("rst_valid", 64'(m_valid), 64'h0);
      check_eq("rst_data", 64'(m_data), 64'h0);
      check_eq("rst_keep", 64'(m_keep), 64'h0);
      check_eq("rst_last", 64'(m_last), 64'h0);
      check_eq("rst_busy", 64'(busy), 64'h0);
      check_eq("rst_rd", 64'(fifo_rd), 64'h0);
      rst_n = 1'b1;
      step(1);

      // One full word, ready held high.
      m_ready = 1'b1;
      base_rd = rd_cnt;
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      step(4);
      check_eq("w1_valid_early", 64'(m_valid), 64'h0);
      step(1);
      check_eq("w1_valid", 64'(m_valid), 64'h1);
      check_eq("w1_data", 64'(m_data), 64'h44332211);
      check_eq("w1_keep", 64'(m_keep), 64'hF);
      check_eq("w1_last", 64'(m_last), 64'h0);
      step(3);
      check_eq("w1_rd_pulses", 64'(rd_cnt - base_rd), 64'd4);
      check_eq("w1_valid_after", 64'(m_valid), 64'h0);

      // Back-pressure: first word held, accumulator fills, reads stop.
      m_ready  = 1'b0;
      base_rd  = rd_cnt;
      base_out = out_n;
      for (int i = 1; i <= 8; i++) push(8'(i * 16'h11));
      step(15);
      check_eq("bp_valid", 64'(m_valid), 64'h1);
      check_eq("bp_data_held", 64'(m_data), 64'h44332211);
      check_eq("bp_rd_pulses", 64'(rd_cnt - base_rd), 64'd8);
      check_eq("bp_rd_idle", 64'(fifo_rd), 64'h0);
      check_eq("bp_busy", 64'(busy), 64'h1);
      m_ready = 1'b1;
      step(1);
      check_eq("bp_w2_valid", 64'(m_valid), 64'h1);
      check_eq("bp_w2_data", 64'(m_data), 64'h88776655);
      check_eq("bp_w2_keep", 64'(m_keep), 64'hF);
      step(1);
      check_eq("bp_valid_after", 64'(m_valid), 64'h0);
      check_eq("bp_words", 64'(out_n - base_out), 64'd2);
      check_eq("bp_log0", 64'(log_data[base_out]), 64'h44332211);

      // Idle timeout on a 2-byte partial word.
      push(8'hAA); push(8'hBB);
      step(18);
      check_eq("to_valid_early", 64'(m_valid), 64'h0);
      step(1);
      check_eq("to_valid", 64'(m_valid), 64'h1);
      check_eq("to_data", 64'(m_data), 64'h0000BBAA);
      check_eq("to_keep", 64'(m_keep), 64'h3);
      check_eq("to_last", 64'(m_last), 64'h1);
      step(2);

      // Flush on the cycle of the last read.
      push(8'h01); push(8'h02); push(8'h03);
      step(2);
      check_eq("fl_rd_at_flush", 64'(fifo_rd), 64'h1);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      step(1);
      check_eq("fl_valid_early", 64'(m_valid), 64'h0);
      step(1);
      check_eq("fl_valid", 64'(m_valid), 64'h1);
      check_eq("fl_data", 64'(m_data), 64'h00030201);
      check_eq("fl_keep", 64'(m_keep), 64'h7);
      check_eq("fl_last", 64'(m_last), 64'h1);
      step(2);

      // Flush with an empty accumulator produces nothing.
      base_out = out_n;
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      step(5);
      check_eq("fl0_words", 64'(out_n - base_out), 64'd0);
      check_eq("fl0_valid", 64'(m_valid), 64'h0);
      check_eq("fl0_busy", 64'(busy), 64'h0);

      // Empty FIFO: no reads.
      base_rd = rd_cnt;
      step(20);
      check_eq("idle_rd_pulses", 64'(rd_cnt - base_rd), 64'd0);

      // 64 bytes with random back-pressure.
      base_rd  = rd_cnt;
      base_out = out_n;
      for (int i = 0; i < 64; i++) push(8'(i * 5 + 3));
      cyc = 0;
      while (out_n < base_out + 16 && cyc < 2000) begin
         @(negedge rd_clk);
         m_ready = 1'($urandom_range(0, 1));
         cyc++;
      end
      m_ready = 1'b1;
      step(1);
      check_eq("rnd_words", 64'(out_n - base_out), 64'd16);
      check_eq("rnd_rd_pulses", 64'(rd_cnt - base_rd), 64'd64);
      for (int k = 0; k < 16; k++) begin
         for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'((4 * k + j) * 5 + 3);
         check_eq($sformatf("rnd_word%0d", k), 64'(log_data[base_out + k]), 64'(w));
         check_eq($sformatf("rnd_kl%0d", k),
                  64'({log_keep[base_out + k], log_last[base_out + k]}), 64'h1E);
      end
      check_eq("rd_while_empty", 64'(empty_rd_viol), 64'd0);

      // Asynchronous reset with acc_cnt = 2 and a word pending.
      m_ready = 1'b0;
      for (int i = 0; i < 6; i++) push(8'(8'hA1 + i));
      step(12);
      check_eq("ar_valid_pre", 64'(m_valid), 64'h1);
      check_eq("ar_busy_pre", 64'(busy), 64'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("ar_valid", 64'(m_valid), 64'h0);
      check_eq("ar_data", 64'(m_data), 64'h0);
      check_eq("ar_keep", 64'(m_keep), 64'h0);
      check_eq("ar_last", 64'(m_last), 64'h0);
      check_eq("ar_busy", 64'(busy), 64'h0);
      check_eq("ar_rd", 64'(fifo_rd), 64'h0);
      @(negedge rd_clk);
      rst_n   = 1'b1;
      m_ready = 1'b1;
      step(1);
      push(8'hC0); push(8'hC1); push(8'hC2); push(8'hC3);
      step(5);
      check_eq("ar_w_valid", 64'(m_valid), 64'h1);
      check_eq("ar_w_data", 64'(m_data), 64'hC3C2C1C0);
      check_eq("ar_w_keep", 64'(m_keep), 64'hF);
      check_eq("ar_w_last", 64'(m_last), 64'h0);
      step(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
